// File: rtl/alu54b_pkg.sv
// Shared widths and record types for the alu54b arbiter slice.
package alu54b_pkg;
  localparam int OPW  = 36;
  localparam int RESW = 55;
  localparam int IDW  = 3;  // wide enough for up to 8 requesters

  typedef struct packed {
    logic           valid;
    logic [IDW-1:0] id;
  } tag_t;

  typedef struct packed {
    logic [IDW-1:0]  id;
    logic [RESW-1:0] data;
  } rsp_entry_t;
endpackage

// File: rtl/alu54b_arbiter_rr_arbiter.sv
// Round-robin arbiter: rotating-priority search from a pointer that only
// moves past the winner when the grant is actually taken.
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic                     enable,
  input  logic                     advance,
  output logic [NREQ-1:0]          grant,
  output logic [$clog2(NREQ)-1:0]  idx,
  output logic                     hit
);
  localparam int IW = $clog2(NREQ);

  logic [IW-1:0] ptr;
  logic [IW:0]   cand;

  // first requester at or after ptr, wrapping modulo NREQ
  always_comb begin
    hit  = 1'b0;
    idx  = '0;
    cand = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = {1'b0, ptr} + (IW+1)'(i);
      if (cand >= (IW+1)'(NREQ)) begin
        cand = cand - (IW+1)'(NREQ);
      end else begin
        cand = cand;
      end
      if (!hit && req[cand[IW-1:0]]) begin
        hit = 1'b1;
        idx = cand[IW-1:0];
      end else begin
        hit = hit;
      end
    end
  end

  // one-hot grant, suppressed when the consumer cannot take an issue
  always_comb begin
    grant = '0;
    if (enable && hit) begin
      grant[idx] = 1'b1;
    end else begin
      grant = '0;
    end
  end

  // pointer moves just past the winner on a taken grant
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (idx == IW'(NREQ-1)) ? '0 : idx + IW'(1);
    end
  end
endmodule

// File: rtl/alu54b_arbiter.sv
// Shares one free-running registered add/sub ALU between NREQ requesters,
// tagging each issue and returning results in order through a credited FIFO.
module alu54b_arbiter
  import alu54b_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int LAT        = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*OPW-1:0]     req_a,
  input  logic [NREQ*OPW-1:0]     req_b,
  input  logic [NREQ-1:0]         req_sub,
  output logic [OPW-1:0]          alu_a,
  output logic [OPW-1:0]          alu_b,
  output logic                    alu_subadd,
  output logic                    alu_ce,
  input  logic [RESW-1:0]         alu_c,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic [RESW-1:0]         rsp_data,
  output logic                    busy
);
  localparam int IW = $clog2(NREQ);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH+1);

  logic            run;
  logic [IW-1:0]   g_idx;
  logic            g_hit;
  logic            issue_ok;
  logic            hs;
  logic            pop;
  logic            push;
  logic [CW-1:0]   credit;
  logic [CW-1:0]   fifo_count;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [OPW-1:0]  last_a;
  logic [OPW-1:0]  last_b;
  logic            last_sub;
  tag_t            tag_pipe [LAT];
  rsp_entry_t      fifo_mem [FIFO_DEPTH];
  rsp_entry_t      head;
  logic            unused_id_bits;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  // credit counts in-flight plus buffered results; a same-cycle pop frees a slot
  assign pop      = rsp_valid & rsp_ready;
  assign issue_ok = run & ((credit < CW'(FIFO_DEPTH)) | pop);
  assign hs       = g_hit & issue_ok;
  assign push     = tag_pipe[LAT-1].valid;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .enable  (issue_ok),
    .advance (hs),
    .grant   (req_ready),
    .idx     (g_idx),
    .hit     (g_hit)
  );

  // operand mux; idle slots repeat the last granted operands
  always_comb begin
    if (hs) begin
      alu_a      = req_a[OPW*g_idx +: OPW];
      alu_b      = req_b[OPW*g_idx +: OPW];
      alu_subadd = req_sub[g_idx];
    end else begin
      alu_a      = last_a;
      alu_b      = last_b;
      alu_subadd = last_sub;
    end
  end

  // ALU enable, held operands, tag pipe and credit counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run      <= 1'b0;
      last_a   <= '0;
      last_b   <= '0;
      last_sub <= 1'b0;
      credit   <= '0;
      for (int i = 0; i < LAT; i++) tag_pipe[i] <= '0;
    end else begin
      run <= 1'b1;
      if (hs) begin
        last_a   <= alu_a;
        last_b   <= alu_b;
        last_sub <= alu_subadd;
      end
      credit      <= credit + CW'(hs) - CW'(pop);
      tag_pipe[0] <= {hs, IDW'(g_idx)};
      for (int i = 1; i < LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  // result FIFO; the tag and the ALU result line up in the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= {tag_pipe[LAT-1].id, alu_c};
        wr_ptr           <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
    end
  end

  assign head           = fifo_mem[rd_ptr];
  assign rsp_valid      = (fifo_count != '0);
  assign rsp_data       = head.data;
  assign rsp_id         = head.id[IW-1:0];
  assign unused_id_bits = ^head.id;
  assign busy           = (credit != '0);
  assign alu_ce         = run;
endmodule

// File: tb/tb_alu54b_arbiter.sv
// Randomised and directed bench for alu54b_arbiter against a queue-based model.
module tb_alu54b_arbiter;
  localparam int N = 4;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*36-1:0] req_a;
  logic [N*36-1:0] req_b;
  logic [N-1:0]   req_sub;
  logic [35:0]    alu_a;
  logic [35:0]    alu_b;
  logic           alu_subadd;
  logic           alu_ce;
  logic [54:0]    alu_c;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [1:0]     rsp_id;
  logic [54:0]    rsp_data;
  logic           busy;

  int errors = 0;
  int checks = 0;

  alu54b_arbiter #(.NREQ(N), .LAT(1), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sub(req_sub),
    .alu_a(alu_a), .alu_b(alu_b), .alu_subadd(alu_subadd), .alu_ce(alu_ce),
    .alu_c(alu_c),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // the external ALU: one registered stage, sign-extended operands
  function automatic logic [54:0] sx(input logic [35:0] v);
    return {{19{v[35]}}, v};
  endfunction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) alu_c <= '0;
    else if (alu_ce) alu_c <= alu_subadd ? sx(alu_a) - sx(alu_b) : sx(alu_a) + sx(alu_b);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int          id;
    logic [54:0] data;
    int          avail;
  } exp_t;
  exp_t        q[$];
  int          cyc = 0;
  int          mptr = 0;
  bit          mrun = 0;
  logic [35:0] hold_a = '0;
  logic [35:0] hold_b = '0;
  logic        hold_s = 1'b0;
  int          dut_occ = 0;
  int          mg;
  int          mj;
  bit          ev;
  bit          mpop;
  bit          allow;
  logic [N-1:0] exp_rdy;
  longint      ea;
  longint      eb;
  longint      er;

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      mptr = 0; mrun = 0; hold_a = '0; hold_b = '0; hold_s = 1'b0; dut_occ = 0;
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_alu_ce", 64'(alu_ce), 64'd0);
    end else begin
      ev = (q.size() != 0) && (q[0].avail <= cyc);
      chk("rsp_valid", 64'(rsp_valid), 64'(ev));
      if (ev) begin
        chk("rsp_id", 64'(rsp_id), 64'(q[0].id));
        chk("rsp_data", 64'(rsp_data), 64'(q[0].data));
      end
      chk("busy", 64'(busy), 64'(q.size() != 0));
      chk("alu_ce", 64'(alu_ce), 64'(mrun));
      mpop = ev && rsp_ready;
      mg = -1;
      for (int k = 0; k < N; k++) begin
        mj = (mptr + k) % N;
        if (mg < 0 && req_valid[mj]) mg = mj;
      end
      allow = mrun && (q.size() < 4 || mpop);
      exp_rdy = '0;
      if (mg >= 0 && allow) exp_rdy[mg] = 1'b1;
      chk("req_ready", 64'(req_ready), 64'(exp_rdy));
      if (exp_rdy != '0) begin
        hold_a = req_a[36*mg +: 36];
        hold_b = req_b[36*mg +: 36];
        hold_s = req_sub[mg];
      end
      chk("alu_a", 64'(alu_a), 64'(hold_a));
      chk("alu_b", 64'(alu_b), 64'(hold_b));
      chk("alu_subadd", 64'(alu_subadd), 64'(hold_s));
      if (mpop) void'(q.pop_front());
      if (exp_rdy != '0) begin
        ea = longint'($signed(hold_a));
        eb = longint'($signed(hold_b));
        er = hold_s ? ea - eb : ea + eb;
        q.push_back('{id: mg, data: er[54:0], avail: cyc + 2});
        mptr = (mg + 1) % N;
      end
      dut_occ += $countones(req_valid & req_ready) - int'(rsp_valid & rsp_ready);
      chk("credit_bound", 64'(dut_occ <= 4), 64'd1);
      mrun = 1;
    end
    cyc++;
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < N; i++) begin
      req_a[36*i +: 36] = 36'({$urandom, $urandom});
      req_b[36*i +: 36] = 36'({$urandom, $urandom});
      req_sub[i]        = 1'($urandom);
    end
  endtask

  task automatic drain();
    int k;
    req_valid = '0;
    rsp_ready = 1'b1;
    k = 0;
    while (busy && k < 50) begin
      tick();
      k++;
    end
    chk("drain_idle", 64'(busy), 64'd0);
  endtask

  logic [N-1:0] prev;
  int           n;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; req_valid = '0; req_a = '0; req_b = '0; req_sub = '0; rsp_ready = 1'b1;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick();

    // all four valid: grants 0..3, responses 0..3 on consecutive cycles
    rand_ops();
    req_valid = 4'hF;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c < 4) chk("rr_order", 64'(req_ready), 64'(4'b0001 << c));
      if (c >= 2) begin
        chk("rr_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("rr_rsp_id", 64'(rsp_id), 64'(c - 2));
      end
      tick();
      if (c == 3) req_valid = '0;
    end

    // single request 2: 5-3
    req_a[72 +: 36] = 36'd5; req_b[72 +: 36] = 36'd3; req_sub[2] = 1'b1;
    req_valid = 4'b0100;
    @(negedge clk); chk("single_grant", 64'(req_ready), 64'h4);
    tick(); req_valid = '0;
    @(negedge clk); chk("single_lat", 64'(rsp_valid), 64'd0);
    tick();
    @(negedge clk);
    chk("single_valid", 64'(rsp_valid), 64'd1);
    chk("single_id", 64'(rsp_id), 64'd2);
    chk("single_data", 64'(rsp_data), 64'd2);
    chk("single_busy", 64'(busy), 64'd1);
    tick();
    @(negedge clk); chk("single_busy_fall", 64'(busy), 64'd0);
    tick();

    // -1 + -1 = -2
    req_a[0 +: 36] = 36'hF_FFFF_FFFF; req_b[0 +: 36] = 36'hF_FFFF_FFFF; req_sub[0] = 1'b0;
    req_valid = 4'b0001;
    @(negedge clk); chk("neg_grant", 64'(req_ready), 64'h1);
    tick(); req_valid = '0;
    @(negedge clk); tick();
    @(negedge clk);
    chk("neg_valid", 64'(rsp_valid), 64'd1);
    chk("neg_id", 64'(rsp_id), 64'd0);
    chk("neg_data", 64'(rsp_data), 64'(55'h7F_FFFF_FFFF_FFFE));
    tick();

    // back-pressure: exactly FIFO_DEPTH issues then stall
    rsp_ready = 1'b0;
    req_valid = 4'hF;
    n = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      n += $countones(req_valid & req_ready);
      tick();
      rand_ops();
    end
    chk("bp_issue_count", 64'(n), 64'd4);
    @(negedge clk); chk("bp_stalled", 64'(req_ready), 64'd0);
    tick();
    rsp_ready = 1'b1;
    repeat (8) begin tick(); rand_ops(); end
    drain();

    // fairness between requesters 0 and 3
    req_valid = 4'b1001;
    prev = '0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("fair_alternate", 64'((req_ready != prev) && (req_ready == 4'b0001 || req_ready == 4'b1000)), 64'd1);
      prev = req_ready;
      tick();
    end
    drain();

    // randomised traffic
    for (int c = 0; c < 1500; c++) begin
      req_valid = 4'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      rand_ops();
      tick();
    end
    drain();

    // async reset with results in flight and buffered
    rsp_ready = 1'b0;
    req_valid = 4'hF;
    rand_ops();
    repeat (4) tick();
    #2;
    rst = 1'b1;
    req_valid = '0;
    #1;
    chk("ar_req_ready", 64'(req_ready), 64'd0);
    chk("ar_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("ar_rsp_id", 64'(rsp_id), 64'd0);
    chk("ar_rsp_data", 64'(rsp_data), 64'd0);
    chk("ar_busy", 64'(busy), 64'd0);
    chk("ar_alu_ce", 64'(alu_ce), 64'd0);
    chk("ar_alu_ops", 64'({alu_a, alu_b, alu_subadd} != '0), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    rsp_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); chk("ar_no_stale", 64'(rsp_valid), 64'd0);
      tick();
    end
    req_a[36 +: 36] = 36'd7; req_b[36 +: 36] = 36'd8; req_sub[1] = 1'b0;
    req_valid = 4'b0010;
    @(negedge clk); chk("ar_grant", 64'(req_ready), 64'h2);
    tick(); req_valid = '0;
    @(negedge clk); tick();
    @(negedge clk);
    chk("ar_valid", 64'(rsp_valid), 64'd1);
    chk("ar_id", 64'(rsp_id), 64'd1);
    chk("ar_data", 64'(rsp_data), 64'd15);
    tick();
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
